// File: rtl/bsg_serial_in_parallel_out_last_pp_pkg.sv
// Shared constants and helpers for the ping-pong serial-in/parallel-out deserialiser.
// len_to_mask is exported so consumers can build the same valid-word mask from len_o.
package bsg_sipo_last_pp_pkg;

    localparam int num_banks_lp  = 2;
    localparam int max_mask_w_lp = 64;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit i set when word i is inside a burst of (len+1) words.
    function automatic logic [max_mask_w_lp-1:0] len_to_mask(input logic [15:0] len);
        logic [max_mask_w_lp-1:0] m;
        for (int i = 0; i < max_mask_w_lp; i++) begin
            m[i] = (16'(i) <= len);
        end
        return m;
    endfunction

endpackage

// File: rtl/bsg_serial_in_parallel_out_last_pp_if.sv
// Serial-in / parallel-out link bundle: narrow word input side and wide burst output side.
// slave is the deserialiser's view; master is the producer/consumer view.
interface bsg_serial_in_parallel_out_last_pp_if
#(
    parameter int width_p   = 8,
    parameter int max_els_p = 4
);
    import bsg_sipo_last_pp_pkg::*;

    localparam int lg_max_els_lp = safe_clog2(max_els_p);

    logic                           v_i;
    logic [width_p-1:0]             data_i;
    logic                           last_i;
    logic                           ready_and_o;
    logic                           v_o;
    logic [max_els_p*width_p-1:0]   data_o;
    logic [lg_max_els_lp-1:0]       len_o;
    logic                           ready_and_i;

    modport slave (
        input  v_i, data_i, last_i, ready_and_i,
        output ready_and_o, v_o, data_o, len_o
    );

    modport master (
        output v_i, data_i, last_i, ready_and_i,
        input  ready_and_o, v_o, data_o, len_o
    );

endinterface

// File: rtl/bsg_serial_in_parallel_out_last_pp_bank.sv
// One ping-pong bank: word storage with per-word write enable, full flag and burst length.
// Data words are intentionally not reset; only full and len are.
module bsg_sipo_last_pp_bank
#(
    parameter int width_p       = 8,
    parameter int max_els_p     = 4,
    parameter int lg_max_els_lp = 2
)
(
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                w_v_i,
    input  logic [lg_max_els_lp-1:0]            w_idx_i,
    input  logic [width_p-1:0]                  w_data_i,
    input  logic                                w_close_i,
    input  logic [lg_max_els_lp-1:0]            w_len_i,
    input  logic                                clear_i,
    output logic                                full_o,
    output logic [max_els_p-1:0][width_p-1:0]   data_o,
    output logic [lg_max_els_lp-1:0]            len_o
);

    logic [max_els_p-1:0][width_p-1:0] data_q, data_d;
    logic                              full_q, full_d;
    logic [lg_max_els_lp-1:0]          len_q, len_d;

    always_comb begin
        data_d = data_q;
        for (int i = 0; i < max_els_p; i++) begin
            if (w_v_i && (w_idx_i == lg_max_els_lp'(i))) data_d[i] = w_data_i;
        end
    end

    // Clear and close never target the same bank in one cycle; close wins if they did.
    always_comb begin
        full_d = full_q;
        if (clear_i)   full_d = 1'b0;
        if (w_close_i) full_d = 1'b1;
        len_d = w_close_i ? w_len_i : len_q;
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_q <= 1'b0;
            len_q  <= '0;
        end else begin
            full_q <= full_d;
            len_q  <= len_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign len_o  = len_q;

endmodule

// File: rtl/bsg_serial_in_parallel_out_last_pp.sv
// Variable-length burst deserialiser with two ping-pong banks; emits burst length with data.
// Optional BSG_SIPO_LAST_PP_ZERO_FILL_EN zeroes output words above len_o.
module bsg_serial_in_parallel_out_last_pp
    import bsg_sipo_last_pp_pkg::*;
#(
    parameter int width_p   = 8,
    parameter int max_els_p = 4
)
(
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    bsg_serial_in_parallel_out_last_pp_if.slave   io
);

    localparam int lg_max_els_lp = safe_clog2(max_els_p);
    localparam logic [lg_max_els_lp-1:0] last_idx_lp = lg_max_els_lp'(max_els_p - 1);

    logic                                              wr_ptr_q, wr_ptr_d;
    logic                                              rd_ptr_q, rd_ptr_d;
    logic [lg_max_els_lp-1:0]                          wcnt_q, wcnt_d;
    logic [num_banks_lp-1:0]                           full;
    logic [num_banks_lp-1:0][max_els_p-1:0][width_p-1:0] bank_data;
    logic [num_banks_lp-1:0][lg_max_els_lp-1:0]        bank_len;
    logic                                              ready, accept, close, deq;
    logic [max_els_p-1:0][width_p-1:0]                 rd_data;
    logic [lg_max_els_lp-1:0]                          rd_len;

    always_comb begin
        ready    = ~full[wr_ptr_q];
        accept   = io.v_i & ready;
        close    = accept & (io.last_i | (wcnt_q == last_idx_lp));
        deq      = full[rd_ptr_q] & io.ready_and_i;
        wr_ptr_d = wr_ptr_q ^ close;
        rd_ptr_d = rd_ptr_q ^ deq;
        wcnt_d   = wcnt_q;
        if (close)       wcnt_d = '0;
        else if (accept) wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wcnt_q   <= wcnt_d;
        end
    end

    for (genvar b = 0; b < num_banks_lp; b++) begin : g_bank
        bsg_sipo_last_pp_bank #(
            .width_p       (width_p),
            .max_els_p     (max_els_p),
            .lg_max_els_lp (lg_max_els_lp)
        ) u_bank (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .w_v_i     (accept & (wr_ptr_q == 1'(b))),
            .w_idx_i   (wcnt_q),
            .w_data_i  (io.data_i),
            .w_close_i (close & (wr_ptr_q == 1'(b))),
            .w_len_i   (wcnt_q),
            .clear_i   (deq & (rd_ptr_q == 1'(b))),
            .full_o    (full[b]),
            .data_o    (bank_data[b]),
            .len_o     (bank_len[b])
        );
    end

    assign rd_data = bank_data[rd_ptr_q];
    assign rd_len  = bank_len[rd_ptr_q];

    assign io.ready_and_o = ready;
    assign io.v_o         = full[rd_ptr_q];
    assign io.len_o       = rd_len;

`ifdef BSG_SIPO_LAST_PP_ZERO_FILL_EN
    logic [max_els_p-1:0] word_mask;
    assign word_mask = max_els_p'(len_to_mask(16'(rd_len)));
    for (genvar i = 0; i < max_els_p; i++) begin : g_zf
        assign io.data_o[i*width_p +: width_p] = word_mask[i] ? rd_data[i] : '0;
    end
`else
    assign io.data_o = rd_data;
`endif

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_last_pp.sv
// Scoreboard bench: max_els_p=4 instance for the main plan, max_els_p=1 instance for streaming.
module tb_bsg_serial_in_parallel_out_last_pp;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  len;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errs;
    exp_t q4[$];
    exp_t q1[$];

    bsg_serial_in_parallel_out_last_pp_if #(.width_p(8), .max_els_p(4)) io4 ();
    bsg_serial_in_parallel_out_last_pp_if #(.width_p(8), .max_els_p(1)) io1 ();

    bsg_serial_in_parallel_out_last_pp #(.width_p(8), .max_els_p(4)) dut4 (
        .clk_i(clk), .reset_n_i(rst_n), .io(io4)
    );
    bsg_serial_in_parallel_out_last_pp #(.width_p(8), .max_els_p(1)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .io(io1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [1:0] l);
        exp_t e;
        e.data = d;
        e.len  = l;
        return e;
    endfunction

    // Output monitors: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && io4.v_o && io4.ready_and_i) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("dut4_len", 32'(io4.len_o), 32'(e.len));
                for (int i = 0; i < 4; i++) begin
                    if (i <= int'(e.len))
                        check("dut4_word", 32'(io4.data_o[i*8 +: 8]), 32'(e.data[i*8 +: 8]));
`ifdef BSG_SIPO_LAST_PP_ZERO_FILL_EN
                    else
                        check("dut4_zero_fill", 32'(io4.data_o[i*8 +: 8]), 32'd0);
`endif
                end
            end
        end
        if (rst_n && io1.v_o && io1.ready_and_i) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_len", 32'(io1.len_o), 32'd0);
                check("dut1_word", 32'(io1.data_o), 32'(e.data[7:0]));
            end
        end
    end

    // Present one word on dut4 until accepted (bounded), then drop valid.
    task automatic put(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        io4.v_i    = 1'b1;
        io4.data_i = d;
        io4.last_i = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (io4.ready_and_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("put_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        io4.v_i    = 1'b0;
        io4.last_i = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        rst_n    = 1'b0;
        io4.v_i = 1'b0; io4.data_i = '0; io4.last_i = 1'b0; io4.ready_and_i = 1'b1;
        io1.v_i = 1'b0; io1.data_i = '0; io1.last_i = 1'b0; io1.ready_and_i = 1'b1;

        #2;
        check("rst_v_o",   32'(io4.v_o), 32'd0);
        check("rst_ready", 32'(io4.ready_and_o), 32'd1);
        check("rst_len",   32'(io4.len_o), 32'd0);
        #21 rst_n = 1'b1;
        step();

        // Full burst with last on the fourth word.
        q4.push_back(mk(32'h44332211, 2'd3));
        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        put(8'h33, 1'b0);
        check("full_no_vo_early", 32'(io4.v_o), 32'd0);
        put(8'h44, 1'b1);
        check("full_vo_latency", 32'(io4.v_o), 32'd1);
        check("full_ready_held", 32'(io4.ready_and_o), 32'd1);
        repeat (3) step();

        // Early close after two words.
        q4.push_back(mk(32'h0000A2A1, 2'd1));
        put(8'hA1, 1'b0);
        put(8'hA2, 1'b1);
        repeat (3) step();

        // Implicit close at max_els_p, fifth word starts a new burst.
        q4.push_back(mk(32'h04030201, 2'd3));
        q4.push_back(mk(32'h00000005, 2'd0));
        for (int i = 1; i <= 4; i++) put(8'(i), 1'b0);
        put(8'h05, 1'b1);
        repeat (4) step();
        check("drained_before_bp", 32'(q4.size()), 32'd0);

        // Backpressure: two one-word bursts fill both banks.
        io4.ready_and_i = 1'b0;
        q4.push_back(mk(32'h000000B0, 2'd0));
        q4.push_back(mk(32'h000000B1, 2'd0));
        q4.push_back(mk(32'h000000B2, 2'd0));
        put(8'hB0, 1'b1);
        put(8'hB1, 1'b1);
        check("bp_ready_low", 32'(io4.ready_and_o), 32'd0);
        check("bp_vo",        32'(io4.v_o), 32'd1);
        check("bp_head_b0",   32'(io4.data_o[7:0]), 32'hB0);
        io4.v_i = 1'b1; io4.data_i = 8'hB2; io4.last_i = 1'b1;
        repeat (2) step();
        check("bp_held_off", 32'(io4.ready_and_o), 32'd0);
        io4.ready_and_i = 1'b1;
        @(negedge clk);
        check("bp_no_bypass", 32'(io4.ready_and_o), 32'd0);
        step();
        io4.ready_and_i = 1'b0;
        check("bp_ready_after_drain", 32'(io4.ready_and_o), 32'd1);
        check("bp_head_b1",           32'(io4.data_o[7:0]), 32'hB1);
        step();
        io4.v_i = 1'b0; io4.last_i = 1'b0;
        check("bp_refilled", 32'(io4.ready_and_o), 32'd0);
        io4.ready_and_i = 1'b1;
        repeat (4) step();
        check("drained_after_bp", 32'(q4.size()), 32'd0);

        // Async reset mid-burst: one bank full, second bank at wcnt=2.
        io4.ready_and_i = 1'b0;
        put(8'hD0, 1'b1);
        put(8'hD1, 1'b0);
        put(8'hD2, 1'b0);
        check("pre_rst_vo", 32'(io4.v_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_vo",    32'(io4.v_o), 32'd0);
        check("async_rst_ready", 32'(io4.ready_and_o), 32'd1);
        #2 rst_n = 1'b1;
        step();
        io4.ready_and_i = 1'b1;
        q4.push_back(mk(32'h000000C0, 2'd0));
        put(8'hC0, 1'b1);
        check("post_rst_vo", 32'(io4.v_o), 32'd1);
        repeat (3) step();

        // max_els_p=1: continuous stream, every word is its own burst.
        for (int i = 0; i < 16; i++) q1.push_back(mk(32'(8'h10 + i), 2'd0));
        for (int i = 0; i < 16; i++) begin
            io1.v_i    = 1'b1;
            io1.data_i = 8'(8'h10 + i);
            @(negedge clk);
            check("m1_no_stall", 32'(io1.ready_and_o), 32'd1);
            step();
        end
        io1.v_i = 1'b0;

        for (int t = 0; t < 20 && (q4.size() != 0 || q1.size() != 0); t++) step();
        check("q4_empty", 32'(q4.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
